// File: rtl/weight_prefetch_pkg.sv
// Shared definitions for the weight prefetch buffer: default geometry and FSM encoding.
package weight_prefetch_pkg;

  localparam int DEF_BIT_WIDTH   = 8;
  localparam int DEF_NUM_CHANNEL = 3;
  localparam int DEF_NUM_KERNEL  = 4;
  localparam int DEF_DAT_WIDTH   = DEF_BIT_WIDTH * DEF_NUM_CHANNEL * DEF_NUM_KERNEL;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_REG_WIDTH   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/weight_prefetch_fifo.sv
// Synchronous first-word-fall-through FIFO holding weight vectors for the PE array.
module weight_fifo #(
  parameter  int DEPTH     = 8,
  parameter  int DAT_WIDTH = 96,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr,
  input  logic [DAT_WIDTH-1:0] i_wdat,
  input  logic                 i_rd,
  output logic [DAT_WIDTH-1:0] o_rdat,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [CW-1:0]        o_count
);

  logic [DEPTH-1:0][DAT_WIDTH-1:0] mem;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == CW'(DEPTH));
  assign o_count = cnt_q;
  // Full + simultaneous read frees the slot being written, so the write is legal.
  assign do_rd   = i_rd && !o_empty;
  assign do_wr   = i_wr && (!o_full || do_rd);
  // Gate the head so an empty FIFO presents zeros rather than stale storage.
  assign o_rdat  = o_empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= i_wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/weight_prefetch.sv
// Credit-gated prefetcher: issues requests to weight_req, buffers returned vectors, feeds the PE array.
module weight_prefetch
  import weight_prefetch_pkg::*;
#(
  parameter  int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter  int NUM_CHANNEL = DEF_NUM_CHANNEL,
  parameter  int NUM_KERNEL  = DEF_NUM_KERNEL,
  parameter  int DEPTH       = DEF_DEPTH,
  parameter  int REG_WIDTH   = DEF_REG_WIDTH,
  localparam int DAT_WIDTH   = BIT_WIDTH * NUM_CHANNEL * NUM_KERNEL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [REG_WIDTH-1:0] i_num_wgt,
  output logic                 o_req,
  input  logic [DAT_WIDTH-1:0] i_wdat,
  input  logic                 i_wvld,
  output logic [DAT_WIDTH-1:0] o_dat,
  output logic                 o_vld,
  input  logic                 i_rdy,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int RW1   = REG_WIDTH + 1;

  state_e               state_q, state_d;
  logic [REG_WIDTH-1:0] num_q, num_d;
  logic [REG_WIDTH-1:0] issued_q, issued_d;
  logic [REG_WIDTH-1:0] consumed_q, consumed_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic                 req_q, req_d;
  logic                 err_q, err_d;

  logic [CNT_W-1:0]     fifo_cnt;
  logic                 fifo_full, fifo_empty, fifo_wr;
  logic                 hs, stray, overflow, accept;
  logic [SUM_W-1:0]     credit_used;
  logic                 credit_ok;

  assign hs       = !fifo_empty && i_rdy;
  assign stray    = i_wvld && (inflight_q == '0);
  assign accept   = i_wvld && !stray;
  assign overflow = accept && fifo_full && !hs;
  assign fifo_wr  = accept && !overflow;

  // A pulse already on o_req still owns a slot even though inflight has not counted it yet.
  assign credit_used = SUM_W'(fifo_cnt) + SUM_W'(inflight_q) + SUM_W'(req_q);
  assign credit_ok   = credit_used < SUM_W'(DEPTH);

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    issued_d   = issued_q + REG_WIDTH'(req_q);
    consumed_d = consumed_q + REG_WIDTH'(hs);
    inflight_d = inflight_q + CNT_W'(req_q) - CNT_W'(accept);
    err_d      = err_q | stray | overflow;
    req_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          num_d      = i_num_wgt;
          issued_d   = '0;
          consumed_d = '0;
          if (i_num_wgt == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            req_d   = credit_ok;
          end
        end
      end
      ST_FETCH: begin
        if (issued_q == num_q) state_d = ST_DRAIN;
        else req_d = ((RW1'(issued_q) + RW1'(req_q)) < RW1'(num_q)) && credit_ok;
      end
      ST_DRAIN: begin
        if (consumed_d == num_q) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      issued_q   <= '0;
      consumed_q <= '0;
      inflight_q <= '0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      consumed_q <= consumed_d;
      inflight_q <= inflight_d;
      req_q      <= req_d;
      err_q      <= err_d;
    end
  end

  weight_fifo #(
    .DEPTH    (DEPTH),
    .DAT_WIDTH(DAT_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .i_wr   (fifo_wr),
    .i_wdat (i_wdat),
    .i_rd   (hs),
    .o_rdat (o_dat),
    .o_full (fifo_full),
    .o_empty(fifo_empty),
    .o_count(fifo_cnt)
  );

  assign o_req  = req_q;
  assign o_vld  = !fifo_empty;
  assign o_busy = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign o_done = (state_q == ST_DONE);
  assign o_err  = err_q;

endmodule

// File: tb/tb_weight_prefetch.sv
// Bench for weight_prefetch: weight_req latency model plus in-order scoreboard of delivered vectors.
module tb_weight_prefetch;
  import weight_prefetch_pkg::*;

  localparam int DW = DEF_BIT_WIDTH * DEF_NUM_CHANNEL * DEF_NUM_KERNEL;
  localparam int RW = DEF_REG_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start, i_rdy;
  logic [RW-1:0] i_num_wgt;
  logic          o_req, o_vld, o_busy, o_done, o_err;
  logic [DW-1:0] o_dat, i_wdat;
  logic          i_wvld;
  logic          mdl_vld, inj_vld;
  logic [DW-1:0] mdl_dat, inj_dat;

  always #5 clk = ~clk;

  assign i_wvld = mdl_vld | inj_vld;
  assign i_wdat = inj_vld ? inj_dat : mdl_dat;

  weight_prefetch dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_num_wgt(i_num_wgt),
    .o_req    (o_req),
    .i_wdat   (i_wdat),
    .i_wvld   (i_wvld),
    .o_dat    (o_dat),
    .o_vld    (o_vld),
    .i_rdy    (i_rdy),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  int errors = 0;
  int checks = 0;

  int cyc = 0, last_due = 0, req_n = 0, ret_cnt = 0, due = 0;
  int pq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w, prev_dat;
  logic stall_prev = 1'b0;
  int req_cnt = 0, done_cnt = 0;
  bit busy_seen = 1'b0;

  function automatic logic [DW-1:0] mk(input int k);
    logic [31:0] w;
    w = 32'(k) ^ 32'h5A00_0000;
    return {w, ~w, w};
  endfunction

  // weight_req model: one return per request, latency 1, every 4th request stalls one extra cycle.
  initial begin
    mdl_vld = 1'b0;
    mdl_dat = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        pq.delete();
        last_due = 0;
        mdl_vld  = 1'b0;
      end else begin
        if (o_req) begin
          due = cyc + ((req_n % 4 == 3) ? 2 : 1);
          if (due <= last_due) due = last_due + 1;
          pq.push_back(due);
          last_due = due;
          req_n++;
        end
        if (pq.size() > 0 && pq[0] == cyc) begin
          void'(pq.pop_front());
          mdl_vld = 1'b1;
          mdl_dat = mk(ret_cnt);
          ret_cnt++;
        end else begin
          mdl_vld = 1'b0;
        end
      end
    end
  end

  // Output monitor: scoreboard pop on handshake, hold check while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
      end else begin
        if (o_req)  req_cnt++;
        if (o_done) done_cnt++;
        if (o_busy) busy_seen = 1'b1;
        if (stall_prev && o_vld) begin
          checks++;
          if (o_dat !== prev_dat) begin
            errors++;
            $display("FAIL hold: o_dat=%h required %h", o_dat, prev_dat);
          end
        end
        if (o_vld && i_rdy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL data: o_dat=%h delivered, required nothing", o_dat);
          end else begin
            exp_w = exp_q.pop_front();
            if (o_dat !== exp_w) begin
              errors++;
              $display("FAIL data: o_dat=%h required %h", o_dat, exp_w);
            end
          end
        end
        stall_prev = o_vld && !i_rdy;
        prev_dat   = o_dat;
      end
    end
  end

  task automatic start_load(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(mk(ret_cnt + k));
    @(posedge clk); #1;
    i_start   = 1'b1;
    i_num_wgt = RW'(n);
    @(posedge clk); #1;
    i_start   = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: o_done=0 after %0d cycles, required 1", tag, limit);
    end
  endtask

  task automatic check_int(input string tag, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", tag, act, req);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_int("reset_outs", int'({o_req, o_vld, o_busy, o_done, o_err}), 0);
    check_int("reset_dat", int'(o_dat == '0), 1);
    @(posedge clk); #3;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int rb = req_cnt, db = done_cnt;
    i_rdy = 1'b1;
    start_load(9);
    wait_done(100, "basic");
    repeat (3) @(negedge clk);
    check_int("basic_reqs", req_cnt - rb, 9);
    check_int("basic_done", done_cnt - db, 1);
    check_int("basic_left", exp_q.size(), 0);
    check_int("basic_err", int'(o_err), 0);
  endtask

  task automatic test_backpressure();
    int rb = req_cnt;
    @(posedge clk); #1;
    i_rdy = 1'b0;
    start_load(20);
    repeat (40) @(negedge clk);
    check_int("bp_reqs_stalled", req_cnt - rb, 8);
    check_int("bp_fifo_cnt", int'(dut.fifo_cnt), 8);
    check_int("bp_inflight", int'(dut.inflight_q), 0);
    check_int("bp_busy", int'(o_busy), 1);
    @(posedge clk); #1;
    i_rdy = 1'b1;
    wait_done(200, "bp");
    repeat (3) @(negedge clk);
    check_int("bp_reqs_total", req_cnt - rb, 20);
    check_int("bp_left", exp_q.size(), 0);
    check_int("bp_err", int'(o_err), 0);
  endtask

  task automatic test_toggle_rdy();
    int db = done_cnt;
    bit seen = 1'b0;
    start_load(12);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      i_rdy = ~i_rdy;
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    check_int("tog_done_seen", int'(seen), 1);
    @(posedge clk); #1;
    i_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_int("tog_done", done_cnt - db, 1);
    check_int("tog_left", exp_q.size(), 0);
    check_int("tog_err", int'(o_err), 0);
  endtask

  task automatic test_zero_load();
    int rb = req_cnt, db = done_cnt, first = -1;
    busy_seen = 1'b0;
    start_load(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_done && first < 0) first = i;
    end
    check_int("zero_done_win", int'(first >= 0 && first <= 1), 1);
    check_int("zero_done", done_cnt - db, 1);
    check_int("zero_reqs", req_cnt - rb, 0);
    check_int("zero_busy", int'(busy_seen), 0);
  endtask

  task automatic test_stray();
    @(posedge clk); #1;
    inj_dat = mk(999);
    inj_vld = 1'b1;
    @(posedge clk); #1;
    inj_vld = 1'b0;
    @(negedge clk);
    check_int("stray_err", int'(o_err), 1);
    check_int("stray_vld", int'(o_vld), 0);
    check_int("stray_cnt", int'(dut.fifo_cnt), 0);
    repeat (5) @(negedge clk);
    check_int("stray_sticky", int'(o_err), 1);
  endtask

  task automatic test_reset_mid_load();
    int n = 0, rb, db;
    start_load(9);
    for (int i = 0; i < 60 && n < 5; i++) begin
      @(negedge clk);
      if (o_req) n++;
    end
    check_int("mid_issued", n, 5);
    #2;
    rst = 1'b0;
    #1;
    check_int("mid_outs", int'({o_req, o_vld, o_busy, o_done, o_err}), 0);
    check_int("mid_dat", int'(o_dat == '0), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    rb = req_cnt;
    db = done_cnt;
    start_load(3);
    wait_done(100, "post");
    repeat (3) @(negedge clk);
    check_int("post_reqs", req_cnt - rb, 3);
    check_int("post_done", done_cnt - db, 1);
    check_int("post_left", exp_q.size(), 0);
    check_int("post_err", int'(o_err), 0);
  endtask

  initial begin
    i_start   = 1'b0;
    i_num_wgt = '0;
    i_rdy     = 1'b0;
    inj_vld   = 1'b0;
    inj_dat   = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle_rdy();
    test_zero_load();
    test_stray();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
